servo_multi_slew: RTL and testbench
===================================

# servo_multi_slew

Multi-channel RC-servo PWM generator with per-channel target registers and optional slew-rate limiting. All channels share one frame counter, default 20 ms at 12 MHz. Each channel drives a pulse whose width encodes its current angle. On each frame boundary the current angle moves toward the written target by at most `SLEW_STEP` degrees. The block sits between control logic (keypad/locker FSMs, UART command decoders) and the servo output pins, and replaces single-channel, instant-jump servo drivers.

## Interface
- `NUM_CH`, 4: number of servo channels (1..16).
- `ANG_W`, 8: angle input width, in degrees.
- `FRAME_CNT`, 240_000: clocks per PWM frame.
- `MIN_CNT`, 6_000: pulse width in clocks at 0°.
- `CNT_PER_DEG`, 134: extra pulse clocks per degree.
- `MAX_ANGLE`, 179: clamp ceiling for targets.
- `SLEW_STEP`, 2: maximum degrees moved per frame; 0 = jump directly to target.
- `RESET_ANGLE`, 90: target and current angle of every channel after reset.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `wr_en`  in  1  target write strobe, one clock.
- `wr_ch`  in  `$clog2(NUM_CH)` (min 1)  channel index for the write.
- `wr_angle`  in  `ANG_W`  requested target angle.
- `servo_pwm`  out  `NUM_CH`  PWM outputs; bit i = channel i.
- `moving`  out  `NUM_CH`  bit i high while channel i's current angle ≠ its target.
- `frame_start`  out  1  one-clock pulse marking the first high cycle of each frame.

## Operation
- Frame counter `cnt` (`$clog2(FRAME_CNT)` bits) counts 0..FRAME_CNT-1, then wraps to 0. It is free-running.
- Per-channel registers:
  - `tgt[i]` and `cur[i]`, each `ANG_W` bits.
  - `width[i]`, wide enough for `MIN_CNT + MAX_ANGLE*CNT_PER_DEG`.
- Elaboration check: `MIN_CNT + MAX_ANGLE*CNT_PER_DEG < FRAME_CNT` and `MAX_ANGLE < 2**ANG_W`. On violation, call `$error`.
- Write handling (any cycle with `wr_en`=1):
  - If `wr_ch >= NUM_CH`, the write is ignored with no state change.
  - Otherwise `tgt[wr_ch] <=` min(`wr_angle`, `MAX_ANGLE`).
  - The write never changes `cur` or `width` directly.
- Frame boundary is the cycle where `cnt == FRAME_CNT-1`. On it, for every channel:
  - If `SLEW_STEP == 0` or |tgt−cur| ≤ `SLEW_STEP`: `cur <= tgt`.
  - Else `cur <= cur ± SLEW_STEP`, toward `tgt`.
  - `width <= MIN_CNT + cur_next*CNT_PER_DEG`, computed at full width with no truncation.
- Boundary uses the `tgt` value registered before that cycle. A write landing on the boundary cycle takes effect at the following boundary.
- Pulse width is therefore constant for the whole frame; a mid-frame write never produces a runt or stretched pulse.
- Outputs (all registered):
  - `servo_pwm[i] <= (cnt < width[i])`.
  - `frame_start <= (cnt == 0)`.
  - `moving[i] <= (cur[i] != tgt[i])`, sampled on register values.
- No FSM beyond the counter. Each channel's slew logic is a three-way compare: below, equal, above.

## Timing
- Reset, applied synchronously on a clk edge:
  - `cnt`=0.
  - `tgt`=`cur`=`RESET_ANGLE`.
  - `width` = `MIN_CNT + RESET_ANGLE*CNT_PER_DEG`.
  - `servo_pwm`=0, `moving`=0, `frame_start`=0.
- After reset deasserts, `cnt`=0 in the first cycle. `servo_pwm` and `frame_start` go high together in the next cycle.
- Each pulse is exactly `width[i]` clocks long. The period is exactly `FRAME_CNT` clocks.
- Write-to-effect latency:
  - A write in frame N changes the pulse in frame N+1 (bounded by `SLEW_STEP`).
  - A write on the boundary cycle of frame N affects frame N+2.
- `moving` lags `cur`/`tgt` changes by one clock.
- Reset mid-pulse forces `servo_pwm` low on the next edge and restarts the frame. Targets are lost.
- Simultaneous write to the same channel on consecutive cycles: the last write wins.

## Test plan
- Reset release, defaults: every `servo_pwm` bit is high for 18_060 clocks, period 240_000 clocks, aligned with `frame_start`. `moving`=0.
- `SLEW_STEP`=0, write ch1 = 0 mid-frame: the current frame stays at 18_060. The next frame pulse on ch1 is 6_000. Other channels are unchanged.
- Clamp: write ch0 = 200 with `SLEW_STEP`=0. The next frame pulse is 29_986 (179°). `tgt[0]` reads 179.
- Slew, `SLEW_STEP`=2:
  - Write ch2 = 99 from 90. Successive frames show 92, 94, 96, 98, 99 (widths 18_328 … 19_266).
  - `moving[2]` is high from the write until the clock after `cur` reaches 99.
- Edge writes:
  - A write on the boundary cycle appears one frame later than a write one cycle earlier.
  - With `NUM_CH`=3, `wr_ch`=3 causes no change.
- Reset asserted mid-pulse: `servo_pwm` drops next clock. All channels return to 90°. The frame restarts at `cnt`=0.

Source files
------------

// File: rtl/servo_multi_slew.sv
// ---------------------------------------------------------------------------
// servo_multi_slew
//
// Multi-channel RC-servo PWM generator. All channels share one free-running
// frame counter. Each channel holds a target angle (written by the host) and
// a current angle. On every frame boundary the current angle steps toward the
// target by at most SLEW_STEP degrees (SLEW_STEP = 0 jumps straight to the
// target). The pulse width is then latched for the next whole frame, so a
// mid-frame write can never produce a runt or stretched pulse.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   wr_en        one-clock target write strobe
//   wr_ch        channel index for the write (indices >= NUM_CH are ignored)
//   wr_angle     requested target angle in degrees (clamped to MAX_ANGLE)
//   servo_pwm    PWM outputs, bit i = channel i
//   moving       bit i high while channel i's current angle differs from its
//                target (one clock behind the registers)
//   frame_start  one-clock pulse on the first high cycle of each frame
// ---------------------------------------------------------------------------
module servo_multi_slew #(
    parameter int NUM_CH      = 4,
    parameter int ANG_W       = 8,
    parameter int FRAME_CNT   = 240_000,
    parameter int MIN_CNT     = 6_000,
    parameter int CNT_PER_DEG = 134,
    parameter int MAX_ANGLE   = 179,
    parameter int SLEW_STEP   = 2,
    parameter int RESET_ANGLE = 90,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W      = $clog2(FRAME_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [ANG_W-1:0]  wr_angle,
    output logic [NUM_CH-1:0] servo_pwm,
    output logic [NUM_CH-1:0] moving,
    output logic              frame_start
);

    // The longest pulse must fit inside a frame, and the angle ceiling must
    // be representable in ANG_W bits.
    if ((MIN_CNT + MAX_ANGLE * CNT_PER_DEG) >= FRAME_CNT || MAX_ANGLE >= (2 ** ANG_W))
    begin : g_param_check
        $error("servo_multi_slew: pulse range exceeds frame or MAX_ANGLE exceeds ANG_W");
    end

    localparam logic [ANG_W-1:0] MAX_A   = ANG_W'(MAX_ANGLE);
    localparam logic [ANG_W-1:0] RST_ANG = ANG_W'(RESET_ANGLE);
    localparam logic [ANG_W-1:0] STEP_A  = ANG_W'(SLEW_STEP);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_CNT - 1);
    // Widths are never larger than the frame length, so the counter width is
    // always enough to hold them and the multiply cannot truncate.
    localparam logic [CNT_W-1:0] RST_WID = CNT_W'(MIN_CNT + RESET_ANGLE * CNT_PER_DEG);
    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] PER_W   = CNT_W'(CNT_PER_DEG);

    logic [CNT_W-1:0] cnt;
    logic             boundary;

    logic [ANG_W-1:0] tgt   [NUM_CH];
    logic [ANG_W-1:0] cur   [NUM_CH];
    logic [CNT_W-1:0] width [NUM_CH];

    logic [ANG_W-1:0] cur_next   [NUM_CH];
    logic [CNT_W-1:0] width_next [NUM_CH];

    logic             wr_valid;
    logic [ANG_W-1:0] wr_clamped;

    assign boundary   = (cnt == LAST);
    assign wr_valid   = wr_en && (int'(wr_ch) < NUM_CH);
    assign wr_clamped = (wr_angle > MAX_A) ? MAX_A : wr_angle;

    // Slew step per channel: three-way compare of target against current.
    // Within one step (or with slewing disabled) the target is taken as-is.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every combinational output gets a default first so no
            // path through the block can leave it unassigned (no latch).
            cur_next[i] = tgt[i];
            if (SLEW_STEP != 0) begin
                if (int'(tgt[i]) - int'(cur[i]) > SLEW_STEP) begin
                    cur_next[i] = cur[i] + STEP_A;      // target above
                end else if (int'(cur[i]) - int'(tgt[i]) > SLEW_STEP) begin
                    cur_next[i] = cur[i] - STEP_A;      // target below
                end
            end
            width_next[i] = MIN_W + CNT_W'(cur_next[i]) * PER_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            frame_start <= 1'b0;
            servo_pwm   <= '0;
            moving      <= '0;
            // NOTE: the per-channel arrays are small registers, not RAM, so
            // they are reset explicitly to restore the power-on angle.
            for (int i = 0; i < NUM_CH; i++) begin
                tgt[i]   <= RST_ANG;
                cur[i]   <= RST_ANG;
                width[i] <= RST_WID;
            end
        end else begin
            // NOTE: all state uses non-blocking assignment, so every
            // comparison below sees the values registered before this edge.
            cnt         <= boundary ? '0 : cnt + 1'b1;
            frame_start <= (cnt == '0);
            for (int i = 0; i < NUM_CH; i++) begin
                servo_pwm[i] <= (cnt < width[i]);
                moving[i]    <= (cur[i] != tgt[i]);
                if (boundary) begin
                    cur[i]   <= cur_next[i];
                    width[i] <= width_next[i];
                end
                // A write on the boundary cycle lands after cur_next was
                // computed from the old target, so it waits a full frame.
                if (wr_valid && (wr_ch == CH_W'(i))) begin
                    tgt[i] <= wr_clamped;
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_multi_slew.sv
// ---------------------------------------------------------------------------
// tb_servo_multi_slew
//
// Two instances on a shortened frame (600 clocks, 60 clocks at 0 deg,
// 3 clocks/deg, so 90 deg = 330, 179 deg = 597):
//   dut_j : SLEW_STEP = 0 (direct jump), 3 channels
//   dut_s : SLEW_STEP = 2, 3 channels
// The stimulus pushes hand-computed pulse widths and per-frame moving flags
// into queues; a monitor measures every finished pulse and every frame start
// and pops the matching expectation.
// ---------------------------------------------------------------------------
module tb_servo_multi_slew;

    localparam int F   = 600;
    localparam int NCH = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en_j, wr_en_s;
    logic [1:0] wr_ch_j, wr_ch_s;
    logic [7:0] wr_angle_j, wr_angle_s;
    logic [2:0] pwm_j, pwm_s, mov_j, mov_s;
    logic       fs_j, fs_s;

    always #5 clk = ~clk;

    servo_multi_slew #(
        .NUM_CH(NCH), .ANG_W(8), .FRAME_CNT(F), .MIN_CNT(60), .CNT_PER_DEG(3),
        .MAX_ANGLE(179), .SLEW_STEP(0), .RESET_ANGLE(90)
    ) dut_j (
        .clk(clk), .rst(rst), .wr_en(wr_en_j), .wr_ch(wr_ch_j), .wr_angle(wr_angle_j),
        .servo_pwm(pwm_j), .moving(mov_j), .frame_start(fs_j)
    );

    servo_multi_slew #(
        .NUM_CH(NCH), .ANG_W(8), .FRAME_CNT(F), .MIN_CNT(60), .CNT_PER_DEG(3),
        .MAX_ANGLE(179), .SLEW_STEP(2), .RESET_ANGLE(90)
    ) dut_s (
        .clk(clk), .rst(rst), .wr_en(wr_en_s), .wr_ch(wr_ch_s), .wr_angle(wr_angle_s),
        .servo_pwm(pwm_s), .moving(mov_s), .frame_start(fs_s)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues: index d*3+c for widths, d for moving (d: 0=j, 1=s).
    int unsigned exp_w [2*NCH][$];
    logic [2:0]  exp_m [2][$];

    task automatic push_w(input int d, input int w0, input int w1, input int w2);
        exp_w[d*NCH+0].push_back(w0);
        exp_w[d*NCH+1].push_back(w1);
        exp_w[d*NCH+2].push_back(w2);
    endtask

    task automatic push_m(input int d, input logic [2:0] m);
        exp_m[d].push_back(m);
    endtask

    // ---------------- monitor ----------------
    int hi_cnt [2][NCH];
    bit prev   [2][NCH];
    int period [2];
    bit seen   [2];

    always @(negedge clk) begin
        logic [2:0] pw [2];
        logic [2:0] mv [2];
        logic       fs [2];
        pw[0] = pwm_j; pw[1] = pwm_s;
        mv[0] = mov_j; mv[1] = mov_s;
        fs[0] = fs_j;  fs[1] = fs_s;
        for (int d = 0; d < 2; d++) begin
            if (rst === 1'b1) begin
                seen[d]   = 1'b0;
                period[d] = 0;
                for (int c = 0; c < NCH; c++) begin
                    hi_cnt[d][c] = 0;
                    prev[d][c]   = 1'b0;
                end
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (pw[d][c] === 1'b1) begin
                        hi_cnt[d][c]++;
                        prev[d][c] = 1'b1;
                    end else begin
                        if (prev[d][c]) begin
                            if (exp_w[d*NCH+c].size() == 0) begin
                                n_chk++;
                                n_err++;
                                $display("FAIL pulse d%0d ch%0d: got width %0d, expected no pulse", d, c, hi_cnt[d][c]);
                            end else begin
                                check($sformatf("width d%0d ch%0d", d, c),
                                      hi_cnt[d][c], exp_w[d*NCH+c].pop_front());
                            end
                        end
                        prev[d][c]   = 1'b0;
                        hi_cnt[d][c] = 0;
                    end
                end
                period[d]++;
                if (fs[d] === 1'b1) begin
                    if (seen[d]) check($sformatf("period d%0d", d), period[d], F);
                    seen[d]   = 1'b1;
                    period[d] = 0;
                    check($sformatf("align d%0d", d), pw[d], 3'b111);
                    if (exp_m[d].size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL moving d%0d: got %0d, expected no frame", d, mv[d]);
                    end else begin
                        check($sformatf("moving d%0d", d), mv[d], exp_m[d].pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int now;

    task automatic advance_to(input int t);
        while (now < t) begin
            @(posedge clk);
            now++;
        end
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        now++;
        wr_en_j = 1'b0;
        wr_en_s = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst pwm j", pwm_j, 3'b000);
        check("rst pwm s", pwm_s, 3'b000);
        check("rst mov j", mov_j, 3'b000);
        check("rst mov s", mov_s, 3'b000);
        check("rst fs j",  fs_j,  1'b0);
        check("rst fs s",  fs_s,  1'b0);
    endtask

    initial begin
        rst = 1'b1;
        wr_en_j = 1'b0; wr_ch_j = '0; wr_angle_j = '0;
        wr_en_s = 1'b0; wr_ch_s = '0; wr_angle_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();

        // dut_j frames 0..5: ch1 -> 0 deg, ch0 -> 200 clamped to 179,
        // ch2 -> 10 one cycle before boundary 1, ch2 -> 20 on boundary 2.
        push_w(0, 330, 330, 330);
        push_w(0, 597,  60, 330);
        push_w(0, 597,  60,  90);
        push_w(0, 597,  60,  90);
        push_w(0, 597,  60, 120);
        push_w(0, 597,  60, 120);
        push_m(0, 3'b000); push_m(0, 3'b000); push_m(0, 3'b000);
        push_m(0, 3'b100); push_m(0, 3'b000); push_m(0, 3'b000);
        push_m(0, 3'b000);
        // dut_s frames 0..5: ch2 90->99 in steps 92,94,96,98,99;
        // ch0 90->87 in frame 2: 88 then 87.
        push_w(1, 330, 330, 330);
        push_w(1, 330, 330, 336);
        push_w(1, 330, 330, 342);
        push_w(1, 324, 330, 348);
        push_w(1, 321, 330, 354);
        push_w(1, 321, 330, 357);
        push_m(1, 3'b000); push_m(1, 3'b100); push_m(1, 3'b100);
        push_m(1, 3'b101); push_m(1, 3'b100); push_m(1, 3'b000);
        push_m(1, 3'b000);

        @(posedge clk);
        #1;
        rst = 1'b0;
        now = 0;

        advance_to(100);
        wr_en_j = 1'b1; wr_ch_j = 2'd1; wr_angle_j = 8'd0;
        wr_en_s = 1'b1; wr_ch_s = 2'd2; wr_angle_s = 8'd99;
        step();

        advance_to(200);
        wr_en_j = 1'b1; wr_ch_j = 2'd0; wr_angle_j = 8'd200;
        step();

        advance_to(1198);
        wr_en_j = 1'b1; wr_ch_j = 2'd2; wr_angle_j = 8'd10;
        step();

        advance_to(1500);
        wr_en_s = 1'b1; wr_ch_s = 2'd0; wr_angle_s = 8'd87;
        step();

        advance_to(1799);
        wr_en_j = 1'b1; wr_ch_j = 2'd2; wr_angle_j = 8'd20;
        step();

        // Out-of-range channel on a 3-channel instance.
        advance_to(2000);
        wr_en_j = 1'b1; wr_ch_j = 2'd3; wr_angle_j = 8'd0;
        step();

        // Reset while every pulse of frame 6 is high (cnt ~ 50).
        advance_to(3650);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        now = 0;

        // Targets lost: everything back at 90 deg.
        push_w(0, 330, 330, 330); push_w(0, 330, 330, 330);
        push_w(1, 330, 330, 330); push_w(1, 330, 330, 330);
        push_m(0, 3'b000); push_m(0, 3'b000); push_m(0, 3'b000);
        push_m(1, 3'b000); push_m(1, 3'b000); push_m(1, 3'b000);

        advance_to(1202);

        for (int q = 0; q < 2*NCH; q++) check($sformatf("leftover width q%0d", q), exp_w[q].size(), 0);
        for (int d = 0; d < 2; d++) check($sformatf("leftover moving d%0d", d), exp_m[d].size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        n_chk++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
